// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and stall handling.
// Optional feature: define ID_EX_BUBBLE_CNT_EN to add the saturating bubble_cnt output.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [3:0]      id_alu_op,
    input  logic [2:0]      id_mask,
    input  logic [2:0]      id_br_type,
    input  logic            id_reg_wr,
    input  logic            id_sel_A,
    input  logic            id_sel_B,
    input  logic            id_rd_en,
    input  logic            id_wr_en,
    input  logic [1:0]      id_wb_sel,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_uses_rs1,
    output logic            ex_uses_rs2,
    output logic [3:0]      ex_alu_op,
    output logic [2:0]      ex_mask,
    output logic [2:0]      ex_br_type,
    output logic            ex_reg_wr,
    output logic            ex_sel_A,
    output logic            ex_sel_B,
    output logic            ex_rd_en,
    output logic            ex_wr_en,
    output logic [1:0]      ex_wb_sel,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [31:0]     bubble_cnt,
`endif
    output logic            load_use_stall
);

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] mask;
        logic [2:0] br_type;
        logic       reg_wr;
        logic       sel_a;
        logic       sel_b;
        logic       rd_en;
        logic       wr_en;
        logic [1:0] wb_sel;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            uses_rs1;
        logic            uses_rs2;
        ctrl_t           ctrl;
    } stage_t;

    stage_t ex_reg;
    stage_t ex_next;
    stage_t id_stage;
    ctrl_t  id_ctrl_raw;

    logic [1:0][4:0] src_idx;
    logic [1:0]      src_used;
    logic [1:0]      src_hit;
    logic            hazard;
    logic            bubble_load;

    assign src_idx[0]  = id_rs1;
    assign src_idx[1]  = id_rs2;
    assign src_used[0] = id_uses_rs1;
    assign src_used[1] = id_uses_rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] & (src_idx[gi] == ex_reg.rd);
        end
    endgenerate

    // Only a load in EX writing a real register can stall a dependent consumer.
    assign hazard = ex_reg.valid & ex_reg.ctrl.rd_en & (ex_reg.rd != 5'd0)
                  & id_valid & (|src_hit);

    assign load_use_stall = hazard & ~flush;
    assign bubble_load    = hazard & ~flush & ~ex_stall;

    always_comb begin
        id_ctrl_raw.alu_op  = id_alu_op;
        id_ctrl_raw.mask    = id_mask;
        id_ctrl_raw.br_type = id_br_type;
        id_ctrl_raw.reg_wr  = id_reg_wr;
        id_ctrl_raw.sel_a   = id_sel_A;
        id_ctrl_raw.sel_b   = id_sel_B;
        id_ctrl_raw.rd_en   = id_rd_en;
        id_ctrl_raw.wr_en   = id_wr_en;
        id_ctrl_raw.wb_sel  = id_wb_sel;

        id_stage.valid    = id_valid;
        id_stage.pc       = id_pc;
        id_stage.rs1_data = id_rs1_data;
        id_stage.rs2_data = id_rs2_data;
        id_stage.imm      = id_imm;
        id_stage.rs1      = id_rs1;
        id_stage.rs2      = id_rs2;
        id_stage.rd       = id_rd;
        id_stage.uses_rs1 = id_uses_rs1;
        id_stage.uses_rs2 = id_uses_rs2;
        // An empty decode slot must not carry any side-effecting control into EX.
        id_stage.ctrl     = id_valid ? id_ctrl_raw : '0;
    end

    always_comb begin
        ex_next = ex_reg;
        if (flush) begin
            ex_next = '0;
        end else if (!ex_stall) begin
            if (hazard) begin
                ex_next = '0;
            end else begin
                ex_next = id_stage;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg <= '0;
        end else begin
            ex_reg <= ex_next;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_reg <= 32'd0;
        end else if (bubble_load && (bubble_cnt_reg != 32'hFFFF_FFFF)) begin
            bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_reg;
`else
    logic unused_bubble;
    assign unused_bubble = bubble_load;
`endif

    assign ex_valid    = ex_reg.valid;
    assign ex_pc       = ex_reg.pc;
    assign ex_rs1_data = ex_reg.rs1_data;
    assign ex_rs2_data = ex_reg.rs2_data;
    assign ex_imm      = ex_reg.imm;
    assign ex_rs1      = ex_reg.rs1;
    assign ex_rs2      = ex_reg.rs2;
    assign ex_rd       = ex_reg.rd;
    assign ex_uses_rs1 = ex_reg.uses_rs1;
    assign ex_uses_rs2 = ex_reg.uses_rs2;
    assign ex_alu_op   = ex_reg.ctrl.alu_op;
    assign ex_mask     = ex_reg.ctrl.mask;
    assign ex_br_type  = ex_reg.ctrl.br_type;
    assign ex_reg_wr   = ex_reg.ctrl.reg_wr;
    assign ex_sel_A    = ex_reg.ctrl.sel_a;
    assign ex_sel_B    = ex_reg.ctrl.sel_b;
    assign ex_rd_en    = ex_reg.ctrl.rd_en;
    assign ex_wr_en    = ex_reg.ctrl.wr_en;
    assign ex_wb_sel   = ex_reg.ctrl.wb_sel;

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage: pass-through, load-use bubble, x0, flush, stall and reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic [3:0]  id_alu_op;
    logic [2:0]  id_mask, id_br_type;
    logic        id_reg_wr, id_sel_A, id_sel_B, id_rd_en, id_wr_en;
    logic [1:0]  id_wb_sel;
    logic        ex_stall, flush;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_uses_rs1, ex_uses_rs2;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_mask, ex_br_type;
    logic        ex_reg_wr, ex_sel_A, ex_sel_B, ex_rd_en, ex_wr_en;
    logic [1:0]  ex_wb_sel;
    logic        load_use_stall;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_alu_op(id_alu_op), .id_mask(id_mask), .id_br_type(id_br_type),
        .id_reg_wr(id_reg_wr), .id_sel_A(id_sel_A), .id_sel_B(id_sel_B),
        .id_rd_en(id_rd_en), .id_wr_en(id_wr_en), .id_wb_sel(id_wb_sel),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_uses_rs1(ex_uses_rs1), .ex_uses_rs2(ex_uses_rs2),
        .ex_alu_op(ex_alu_op), .ex_mask(ex_mask), .ex_br_type(ex_br_type),
        .ex_reg_wr(ex_reg_wr), .ex_sel_A(ex_sel_A), .ex_sel_B(ex_sel_B),
        .ex_rd_en(ex_rd_en), .ex_wr_en(ex_wr_en), .ex_wb_sel(ex_wb_sel),
`ifdef ID_EX_BUBBLE_CNT_EN
        .bubble_cnt(bubble_cnt),
`endif
        .load_use_stall(load_use_stall)
    );

    typedef struct {
        logic        rst, flush, stall, valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2;
        logic        uses1, uses2;
        logic [4:0]  rd;
        logic        rd_en;
        logic [3:0]  alu;
        logic        reg_wr;
        logic [31:0] imm;
        logic        e_lus, e_valid;
        logic [31:0] e_pc;
        logic [4:0]  e_rs1, e_rd;
        logic        e_rd_en;
        logic [3:0]  e_alu;
        logic        e_reg_wr;
        logic [31:0] e_imm;
        logic        e_ctrl;
        int          e_cnt;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst         = v.rst;
        flush       = v.flush;
        ex_stall    = v.stall;
        id_valid    = v.valid;
        id_pc       = v.pc;
        id_rs1_data = v.pc + 32'd1;
        id_rs2_data = v.pc + 32'd2;
        id_imm      = v.imm;
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_uses_rs1 = v.uses1;
        id_uses_rs2 = v.uses2;
        id_rd       = v.rd;
        id_rd_en    = v.rd_en;
        id_alu_op   = v.alu;
        id_reg_wr   = v.reg_wr;
        id_mask     = 3'd3;
        id_br_type  = 3'd2;
        id_sel_A    = 1'b1;
        id_sel_B    = 1'b1;
        id_wr_en    = 1'b1;
        id_wb_sel   = 2'd1;
    endtask

    initial begin
        // Field order: rst flush stall valid pc rs1 rs2 uses1 uses2 rd rd_en alu reg_wr imm |
        //              e_lus e_valid e_pc e_rs1 e_rd e_rd_en e_alu e_reg_wr e_imm e_ctrl e_cnt
        vecs[0]  = '{0,0,0,1,32'h100, 1,2,1,1, 7,0, 9,1,32'h55, 0, 1,32'h100,1,7,0,9,1,32'h55,1, 0};
        vecs[1]  = '{0,0,0,1,32'h104, 2,0,1,0, 5,1, 0,1,32'h10, 0, 1,32'h104,2,5,1,0,1,32'h10,1, 0};
        vecs[2]  = '{0,0,0,1,32'h108, 5,6,1,1, 8,0, 1,1,32'h0,  1, 0,32'h0,0,0,0,0,0,32'h0,0,    1};
        vecs[3]  = '{0,0,0,1,32'h108, 5,6,1,1, 8,0, 1,1,32'h0,  0, 1,32'h108,5,8,0,1,1,32'h0,1,  1};
        vecs[4]  = '{0,0,0,1,32'h10C, 8,0,1,0, 0,1, 0,1,32'h4,  0, 1,32'h10C,8,0,1,0,1,32'h4,1,  1};
        vecs[5]  = '{0,0,0,1,32'h110, 0,0,1,1, 9,0, 2,1,32'h0,  0, 1,32'h110,0,9,0,2,1,32'h0,1,  1};
        vecs[6]  = '{0,0,0,1,32'h114, 1,0,1,0, 6,1, 0,1,32'h8,  0, 1,32'h114,1,6,1,0,1,32'h8,1,  1};
        vecs[7]  = '{0,0,0,1,32'h118, 3,6,1,0,10,0, 3,1,32'h0,  0, 1,32'h118,3,10,0,3,1,32'h0,1, 1};
        vecs[8]  = '{0,0,0,1,32'h11C, 0,0,0,0, 7,1, 0,1,32'hC,  0, 1,32'h11C,0,7,1,0,1,32'hC,1,  1};
        vecs[9]  = '{0,1,1,1,32'h120, 0,7,0,1,11,0, 4,1,32'h0,  0, 0,32'h0,0,0,0,0,0,32'h0,0,    1};
        vecs[10] = '{0,0,0,0,32'h124, 4,0,1,0,12,1, 5,1,32'h20, 0, 0,32'h124,4,12,0,0,0,32'h20,0,1};
        vecs[11] = '{0,0,0,1,32'h128, 1,0,1,0, 3,1, 0,1,32'h30, 0, 1,32'h128,1,3,1,0,1,32'h30,1, 1};
        vecs[12] = '{0,0,1,1,32'h12C, 3,0,1,0,13,0, 6,1,32'h0,  1, 1,32'h128,1,3,1,0,1,32'h30,1, 1};
        vecs[13] = '{0,0,0,1,32'h12C, 3,0,1,0,13,0, 6,1,32'h0,  1, 0,32'h0,0,0,0,0,0,32'h0,0,    2};
        vecs[14] = '{0,0,0,1,32'h12C, 3,0,1,0,13,0, 6,1,32'h0,  0, 1,32'h12C,3,13,0,6,1,32'h0,1, 2};
        vecs[15] = '{0,0,1,1,32'h130,13,0,1,0,14,1, 7,1,32'h0,  0, 1,32'h12C,3,13,0,6,1,32'h0,1, 2};
        vecs[16] = '{0,0,1,1,32'h130,13,0,1,0,14,1, 7,1,32'h0,  0, 1,32'h12C,3,13,0,6,1,32'h0,1, 2};
        vecs[17] = '{1,0,1,1,32'h130,13,0,1,0,14,1, 7,1,32'h0,  0, 0,32'h0,0,0,0,0,0,32'h0,0,    0};
        vecs[18] = '{0,0,0,1,32'h200, 5,0,1,0, 5,1,15,1,32'h77, 0, 1,32'h200,5,5,1,15,1,32'h77,1,0};

        // Reset sequence with a decode slot that reads x5
        drive(vecs[0]);
        rst = 1'b1;
        id_rs1 = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ex_valid", -1, {31'd0, ex_valid}, 32'd0);
        chk("reset_ex_pc", -1, ex_pc, 32'd0);
        chk("reset_ex_rd_en", -1, {31'd0, ex_rd_en}, 32'd0);
        chk("reset_lus", -1, {31'd0, load_use_stall}, 32'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("reset_bubble_cnt", -1, bubble_cnt, 32'd0);
`endif

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk("load_use_stall", i, {31'd0, load_use_stall}, {31'd0, vecs[i].e_lus});
            @(posedge clk);
            #1;
            chk("ex_valid", i, {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
            chk("ex_pc", i, ex_pc, vecs[i].e_pc);
            chk("ex_rs1_data", i, ex_rs1_data, (vecs[i].e_pc == 32'd0) ? 32'd0 : vecs[i].e_pc + 32'd1);
            chk("ex_rs2_data", i, ex_rs2_data, (vecs[i].e_pc == 32'd0) ? 32'd0 : vecs[i].e_pc + 32'd2);
            chk("ex_imm", i, ex_imm, vecs[i].e_imm);
            chk("ex_rs1", i, {27'd0, ex_rs1}, {27'd0, vecs[i].e_rs1});
            chk("ex_rd", i, {27'd0, ex_rd}, {27'd0, vecs[i].e_rd});
            chk("ex_rd_en", i, {31'd0, ex_rd_en}, {31'd0, vecs[i].e_rd_en});
            chk("ex_alu_op", i, {28'd0, ex_alu_op}, {28'd0, vecs[i].e_alu});
            chk("ex_reg_wr", i, {31'd0, ex_reg_wr}, {31'd0, vecs[i].e_reg_wr});
            chk("ex_ctrl_fixed", i,
                {20'd0, ex_mask, ex_br_type, ex_sel_A, ex_sel_B, ex_wr_en, ex_wb_sel},
                vecs[i].e_ctrl ? {20'd0, 3'd3, 3'd2, 1'b1, 1'b1, 1'b1, 2'd1} : 32'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
            chk("bubble_cnt", i, bubble_cnt, vecs[i].e_cnt);
`endif
            $display("vec=%0d rst=%0b flush=%0b stall=%0b lus=%0b ex_valid=%0b ex_pc=0x%0h ex_rd=%0d",
                     i, vecs[i].rst, vecs[i].flush, vecs[i].stall, load_use_stall, ex_valid, ex_pc, ex_rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, the data-path width of pc, operand and immediate fields.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port id_valid  input  1  decode stage holds a real instruction.
REQ-005 SHALL have ports id_pc, id_rs1_data, id_rs2_data, id_imm  input  XLEN  decoded pc, register-file read data and immediate.
REQ-006 SHALL have ports id_rs1, id_rs2, id_rd  input  5  source and destination register indices.
REQ-007 SHALL have ports id_uses_rs1, id_uses_rs2  input  1  instruction actually reads rs1/rs2.
REQ-008 SHALL have control inputs from the decoder: id_alu_op 4, id_mask 3, id_br_type 3, id_reg_wr 1, id_sel_A 1, id_sel_B 1, id_rd_en 1, id_wr_en 1, id_wb_sel 2.
REQ-009 SHALL have port ex_stall  input  1  execute/memory side cannot accept; hold register.
REQ-010 SHALL have port flush  input  1  taken branch/jump resolved; kill the instruction entering EX.
REQ-011 SHALL have registered outputs ex_valid 1 and ex_<field> mirroring every id_ field of REQ-005..REQ-008 at the same width.
REQ-012 SHALL have port load_use_stall  output  1  combinational; hold PC and IF/ID this cycle.

Function
REQ-013 SHALL compute hazard = ex_valid & ex_rd_en & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
REQ-014 SHALL drive load_use_stall = hazard & ~flush, with no registered delay.
REQ-015 SHALL apply, per rising edge, the priority rst > flush > ex_stall > hazard > normal load.
REQ-016 SHALL on flush or hazard load a bubble: ex_valid=0 and every ex_ output (control and data) = 0.
REQ-017 SHALL on ex_stall (no rst, no flush) hold every ex_ output and ex_valid unchanged.
REQ-018 SHALL on normal load capture all id_ fields with one-cycle latency; ex_valid = id_valid.
REQ-019 SHALL, when id_valid=0 on a normal load, force all ex_ control outputs to 0 so no write, load, store or branch side effects occur.
REQ-020 SHALL insert exactly one bubble per load-use pair; next cycle ex_rd_en=0 so load_use_stall deasserts and the held instruction loads.
REQ-021 SHALL never flag a hazard on rd = x0 or on a source the instruction does not use.
REQ-022 SHALL give flush precedence over a simultaneous hazard: bubble loaded, load_use_stall=0.
REQ-023 SHALL keep load_use_stall asserted while ex_stall and hazard are both true, and not count it as a new bubble.

Reset
REQ-024 SHALL on rst=1 at a rising edge clear ex_valid and every ex_ output to 0, regardless of flush, ex_stall or hazard.
REQ-025 SHALL, since load_use_stall depends on ex_valid, produce load_use_stall=0 in the first cycle after reset.
REQ-026 SHALL discard any instruction held mid-stall when reset arrives; no state survives reset.

Configuration
REQ-027 SHALL, when ID_EX_BUBBLE_CNT_EN is defined, add output bubble_cnt (32 bits), reset to 0, incremented on each edge where a load-use bubble is loaded (hazard & ~flush & ~ex_stall & ~rst), saturating at 0xFFFF_FFFF.
REQ-028 SHALL, when ID_EX_BUBBLE_CNT_EN is undefined, omit bubble_cnt and its counter entirely, with all other behaviour identical.

Verification
REQ-029 SHALL cover plain pass-through: id_valid=1, id_pc=0x100, id_alu_op=9, id_reg_wr=1 -> next edge ex_pc=0x100, ex_alu_op=9, ex_reg_wr=1, ex_valid=1.
REQ-030 SHALL cover load-use: EX holds lw x5 (ex_rd_en=1, ex_rd=5); ID add uses rs1=5 -> load_use_stall=1, one bubble (ex_valid=0, ex_reg_wr=0); following edge add loads; bubble_cnt=1 if enabled.
REQ-031 SHALL cover the x0 case: EX lw x0, ID reads rs1=0 -> load_use_stall=0, no bubble.
REQ-032 SHALL cover flush concurrent with hazard and ex_stall: flush=1 -> ex_valid=0, all controls 0, load_use_stall=0, bubble_cnt unchanged.
REQ-033 SHALL cover stall hold then reset: ex_stall=1 for 3 cycles -> outputs frozen; rst=1 on 3rd -> all ex_ outputs 0 next edge.
